// File: rtl/if_stage_pc_if.sv
// Fetch-stage bus: hazard/redirect controls and the imem read port going in,
// PC and IF/ID pipeline latch coming out.
interface if_stage_pc_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instr_in;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    // Driver side: pipeline control logic and instruction memory.
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               jr, jr_target, instr_in,
        input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );

    // Fetch-stage side.
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               jr, jr_target, instr_in,
        output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID
// pipeline latch. A redirect squashes the instruction being fetched (one bubble)
// and wins over a stall, since the fetched instruction is on the wrong path anyway.
module if_stage_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst_n,
    if_stage_pc_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    assign redirect = bus.jr | bus.branch_taken | bus.jump;
    assign pc_plus4 = pc_q + 32'd4;

    // Redirect target priority: jr (EX) > branch (EX) > jump (ID).
    always_comb begin
        redirect_target = bus.jump_target;
        if (bus.jr) begin
            redirect_target = bus.jr_target;
        end else if (bus.branch_taken) begin
            redirect_target = bus.branch_target;
        end
    end

    // Next-state selection: redirect, then stall, then sequential fetch.
    always_comb begin
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;
        if (redirect) begin
            pc_d            = redirect_target & ~32'h3;
            ifid_instr_d    = NOP_INSTR;
            ifid_pc_plus4_d = 32'h0;
            ifid_valid_d    = 1'b0;
        end else if (!bus.stall) begin
            pc_d            = pc_plus4;
            ifid_instr_d    = bus.instr_in;
            ifid_pc_plus4_d = pc_plus4;
            ifid_valid_d    = 1'b1;
            fetch_count_d   = fetch_count_q + 32'd1;
        end
    end

    // PC and IF/ID register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus4_q <= 32'h0;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= 32'h0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.pc            = pc_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.fetch_count   = fetch_count_q;

endmodule
